// File: rtl/demorgan_checker.sv
// demorgan_checker
// On-chip self-test engine for a gate-level De Morgan unit. It walks the
// unit's A/B inputs through 00, 01, 10, 11, holds each for SETTLE cycles,
// then checks all six outputs against the De Morgan truth table.
//
// Parameters:
//   SETTLE     cycles A/B are held before sampling (1..15)
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous, active-high reset
//   start      begin a run (accepted only when idle)
//   A, B       registered stimulus to the unit under test
//   nA .. n_AandB  observed outputs of the unit under test
//   busy       run in progress (drive or sample phase)
//   done       one-cycle completion strobe
//   pass       last completed run had no failing vector
//   err_count  number of failing vectors (0..4)
//   fail_vec   bit i set when vector i = {A,B} failed
// Build option:
//   DEMORGAN_CHECK_HALT_EN  stop the run at the first failing vector
module demorgan_checker #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       A,
    output logic       B,
    input  logic       nA,
    input  logic       nB,
    input  logic       nAandnB,
    input  logic       n_AorB,
    input  logic       nAornB,
    input  logic       n_AandB,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StDrive  = 2'd1;
    localparam logic [1:0] StSample = 2'd2;
    localparam logic [1:0] StDone   = 2'd3;

    localparam logic [3:0] SettleLast = 4'(SETTLE - 1);

    logic [1:0] stateQ, stateD;
    logic [1:0] vecQ, vecD;
    logic [3:0] cntQ, cntD;
    logic       aQ, aD;
    logic       bQ, bD;
    logic       passQ, passD;
    logic [2:0] errQ, errD;
    logic [3:0] failQ, failD;

    logic [5:0] observed;
    logic [5:0] expected;
    logic       mismatch;
    logic [1:0] vecInc;
    logic       lastVec;

    assign observed = {nA, nB, nAandnB, n_AorB, nAornB, n_AandB};
    // Golden outputs derived from the stimulus actually being driven.
    assign expected = {~aQ, ~bQ, ~aQ & ~bQ, ~(aQ | bQ), ~aQ | ~bQ, ~(aQ & bQ)};
    assign mismatch = (observed != expected);
    assign vecInc   = vecQ + 2'd1;

`ifdef DEMORGAN_CHECK_HALT_EN
    assign lastVec = (vecQ == 2'd3) || mismatch;
`else
    assign lastVec = (vecQ == 2'd3);
`endif

    always_comb begin
        stateD = stateQ;
        vecD   = vecQ;
        cntD   = cntQ;
        aD     = aQ;
        bD     = bQ;
        passD  = passQ;
        errD   = errQ;
        failD  = failQ;
        unique case (stateQ)
            StIdle: begin
                if (start) begin
                    stateD = StDrive;
                    vecD   = 2'd0;
                    cntD   = 4'd0;
                    aD     = 1'b0;
                    bD     = 1'b0;
                    passD  = 1'b0;
                    errD   = 3'd0;
                    failD  = 4'd0;
                end
            end
            StDrive: begin
                if (cntQ == SettleLast) begin
                    stateD = StSample;
                end else begin
                    cntD = cntQ + 4'd1;
                end
            end
            StSample: begin
                if (mismatch) begin
                    failD[vecQ] = 1'b1;
                    errD        = errQ + 3'd1;
                end
                if (lastVec) begin
                    stateD = StDone;
                    aD     = 1'b0;
                    bD     = 1'b0;
                    // Loaded on entry so pass is already valid while done is high.
                    passD  = (errD == 3'd0);
                end else begin
                    stateD = StDrive;
                    vecD   = vecInc;
                    cntD   = 4'd0;
                    aD     = vecInc[1];
                    bD     = vecInc[0];
                end
            end
            StDone: begin
                stateD = StIdle;
            end
            default: begin
                stateD = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ <= StIdle;
            vecQ   <= 2'd0;
            cntQ   <= 4'd0;
            aQ     <= 1'b0;
            bQ     <= 1'b0;
            passQ  <= 1'b0;
            errQ   <= 3'd0;
            failQ  <= 4'd0;
        end else begin
            stateQ <= stateD;
            vecQ   <= vecD;
            cntQ   <= cntD;
            aQ     <= aD;
            bQ     <= bD;
            passQ  <= passD;
            errQ   <= errD;
            failQ  <= failD;
        end
    end

    assign A         = aQ;
    assign B         = bQ;
    assign busy      = (stateQ == StDrive) || (stateQ == StSample);
    assign done      = (stateQ == StDone);
    assign pass      = passQ;
    assign err_count = errQ;
    assign fail_vec  = failQ;

endmodule

// File: tb/tb_demorgan_checker.sv
module tb_demorgan_checker;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // Instance under SETTLE=1 with a fault-injectable gate model.
    logic       start1 = 1'b0;
    logic       a1, b1, busy1, done1, pass1;
    logic [2:0] ec1;
    logic [3:0] fv1;
    logic [5:0] obs1;
    int         fault = 0;

    // Instance under SETTLE=3 with a fault-free gate model.
    logic       start3 = 1'b0;
    logic       a3, b3, busy3, done3, pass3;
    logic [2:0] ec3;
    logic [3:0] fv3;
    logic [5:0] obs3;

    // Gate model: bits {nA, nB, nAandnB, n_AorB, nAornB, n_AandB}.
    function automatic logic [5:0] gateModel(input logic a, input logic b, input int f);
        logic [5:0] r;
        r = {~a, ~b, ~a & ~b, ~(a | b), ~a | ~b, ~(a & b)};
        case (f)
            1: r[0] = 1'b1;   // n_AandB stuck at 1
            2: r[5] = 1'b0;   // nA stuck at 0
            3: r[4] = 1'b1;   // nB stuck at 1
            4: r[1] = 1'b0;   // nAornB stuck at 0
            5: r = ~r;        // every output inverted
            default: ;
        endcase
        return r;
    endfunction

    assign obs1 = gateModel(a1, b1, fault);
    assign obs3 = gateModel(a3, b3, 0);

    demorgan_checker #(.SETTLE(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .A(a1), .B(b1),
        .nA(obs1[5]), .nB(obs1[4]), .nAandnB(obs1[3]), .n_AorB(obs1[2]),
        .nAornB(obs1[1]), .n_AandB(obs1[0]),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(ec1), .fail_vec(fv1)
    );

    demorgan_checker #(.SETTLE(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .A(a3), .B(b3),
        .nA(obs3[5]), .nB(obs3[4]), .nAandnB(obs3[3]), .n_AorB(obs3[2]),
        .nAornB(obs3[1]), .n_AandB(obs3[0]),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(ec3), .fail_vec(fv3)
    );

    int nChecks = 0;
    int nFails  = 0;

    task automatic check(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [3:0] fv;
        logic [2:0] ec;
        logic       ps;
        int         lat;
    } exp_t;

    exp_t sbQ[$];

    typedef struct {
        int         fault;
        logic [3:0] fv;
        logic [2:0] ec;
        logic [3:0] fvHalt;
        int         latHalt;
    } vec_t;

    // Pulse start on dut1, follow the A/B walk, and score the result at done.
    task automatic runOne(input string tag);
        bit   seen;
        exp_t e;
        seen = 1'b0;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (n > 0) begin
                @(posedge clk);
                #1;
            end
            if (done1) begin
                seen = 1'b1;
                if (sbQ.size() == 0) begin
                    check({tag, "_sb_empty"}, 1, 0);
                end else begin
                    e = sbQ.pop_front();
                    check({tag, "_latency"}, n, e.lat);
                    check({tag, "_fail_vec"}, int'(fv1), int'(e.fv));
                    check({tag, "_err_count"}, int'(ec1), int'(e.ec));
                    @(posedge clk);
                    #1;
                    check({tag, "_done_width"}, int'(done1), 0);
                    check({tag, "_pass"}, int'(pass1), int'(e.ps));
                end
                break;
            end
            check({tag, "_ab_seq"}, int'({a1, b1}), n / 2);
            check({tag, "_busy"}, int'(busy1), 1);
        end
        if (!seen) check({tag, "_done_timeout"}, 0, 1);
    endtask

    vec_t tbl[6];

    initial begin
        exp_t e;
        int   pulses;
        bit   seen;

        tbl[0] = '{0, 4'b0000, 3'd0, 4'b0000, 8};
        tbl[1] = '{1, 4'b1000, 3'd1, 4'b1000, 8};
        tbl[2] = '{2, 4'b0011, 3'd2, 4'b0001, 2};
        tbl[3] = '{3, 4'b1010, 3'd2, 4'b0010, 4};
        tbl[4] = '{4, 4'b0111, 3'd3, 4'b0001, 2};
        tbl[5] = '{5, 4'b1111, 3'd4, 4'b0001, 2};

        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ab", int'({a1, b1}), 0);
        check("rst_busy", int'(busy1), 0);
        check("rst_done", int'(done1), 0);
        check("rst_pass", int'(pass1), 0);
        check("rst_err_count", int'(ec1), 0);
        check("rst_fail_vec", int'(fv1), 0);
        @(negedge clk);
        reset = 1'b0;

        foreach (tbl[i]) begin
            fault = tbl[i].fault;
`ifdef DEMORGAN_CHECK_HALT_EN
            e.fv  = tbl[i].fvHalt;
            e.ec  = (tbl[i].fvHalt != 4'd0) ? 3'd1 : 3'd0;
            e.lat = tbl[i].latHalt;
`else
            e.fv  = tbl[i].fv;
            e.ec  = tbl[i].ec;
            e.lat = 8;
`endif
            e.ps = (e.ec == 3'd0);
            sbQ.push_back(e);
            runOne($sformatf("vec%0d", i));
        end

        // SETTLE=3: each A/B value held four cycles, done 16 edges after start.
        seen = 1'b0;
        @(negedge clk);
        start3 = 1'b1;
        @(posedge clk);
        #1;
        start3 = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (n > 0) begin
                @(posedge clk);
                #1;
            end
            if (done3) begin
                seen = 1'b1;
                check("s3_latency", n, 16);
                check("s3_err_count", int'(ec3), 0);
                check("s3_fail_vec", int'(fv3), 0);
                @(posedge clk);
                #1;
                check("s3_pass", int'(pass3), 1);
                break;
            end
            check("s3_ab_seq", int'({a3, b3}), n / 4);
        end
        if (!seen) check("s3_done_timeout", 0, 1);

        // Asynchronous reset during vector 2, then a clean rerun.
        fault = 0;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mid_ab_vec2", int'({a1, b1}), 2);
        check("mid_busy", int'(busy1), 1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_ab", int'({a1, b1}), 0);
        check("mid_rst_busy", int'(busy1), 0);
        check("mid_rst_err_count", int'(ec1), 0);
        check("mid_rst_fail_vec", int'(fv1), 0);
        check("mid_rst_pass", int'(pass1), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_no_restart", int'(busy1), 0);
        e.fv = 4'd0; e.ec = 3'd0; e.ps = 1'b1; e.lat = 8;
        sbQ.push_back(e);
        runOne("after_rst");

        // start held high for 20 edges: two runs, second accepted after DONE.
        pulses = 0;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 1; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (done1) pulses++;
            if (k == 8) check("held_done_t8", int'(done1), 1);
            if (k == 9) begin
                check("held_idle_busy", int'(busy1), 0);
                check("held_idle_pass", int'(pass1), 1);
            end
            if (k == 10) begin
                check("held_rerun_busy", int'(busy1), 1);
                check("held_rerun_pass", int'(pass1), 0);
            end
        end
        @(negedge clk);
        start1 = 1'b0;
        check("held_done_pulses", pulses, 2);
        repeat (2) @(posedge clk);
        #1;
        check("held_final_idle", int'(busy1), 0);
        check("sb_drained", sbQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/demorgan_checker.md
# demorgan_checker

Sequential stimulus-and-check engine that sits at the consuming end of the `demorgan` gate block. It drives the `A`/`B` inputs of a `demorgan` instance through all four input combinations and samples the six `demorgan` outputs against the expected De Morgan truth table. It then reports per-vector failures and an overall pass/fail. It serves as the on-chip self-test companion for the gate-level De Morgan unit.

## Interface
- `SETTLE`, default 1: cycles `A`/`B` are held before the DUT outputs are sampled; legal range 1–15.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high; forces all state and outputs to reset values immediately.
- `start` input 1: begin a run; sampled only in IDLE.
- `A` output 1: stimulus to the DUT `A` input.
- `B` output 1: stimulus to the DUT `B` input.
- `nA` input 1: DUT observed output.
- `nB` input 1: DUT observed output.
- `nAandnB` input 1: DUT observed output.
- `n_AorB` input 1: DUT observed output.
- `nAornB` input 1: DUT observed output.
- `n_AandB` input 1: DUT observed output.
- `busy` output 1: high in DRIVE or SAMPLE.
- `done` output 1: high for exactly one cycle, in state DONE.
- `pass` output 1: result of the last completed run; high iff `err_count == 0`; held until the next `start` is accepted.
- `err_count` output 3: number of failing vectors in the current/last run, 0–4.
- `fail_vec` output 4: bit i set if vector i failed; vector index i = {A,B}.

## Operation
- **States:** IDLE, DRIVE, SAMPLE, DONE.
- **Registers:** 2-bit vector index `vec`; 4-bit settle counter `cnt`.
- **`A`/`B` drive:** `A = vec[1]`, `B = vec[0]`, registered. They are 0 in IDLE and DONE.
- **IDLE:**
  - `start = 1` → DRIVE.
  - On that transition: `vec = 0`, `cnt = 0`, `fail_vec = 0`, `err_count = 0`, `pass = 0`.
- **DRIVE:**
  - `cnt == SETTLE-1` → SAMPLE.
  - Otherwise `cnt` increments.
- **SAMPLE:**
  - Compare all six inputs to the expected values:
    - `nA = ~A`
    - `nB = ~B`
    - `nAandnB = ~A & ~B`
    - `n_AorB = ~(A | B)`
    - `nAornB = ~A | ~B`
    - `n_AandB = ~(A & B)`
  - Any mismatch sets `fail_vec[vec]` and increments `err_count`.
  - Then: `vec == 3` → DONE; otherwise `vec++`, `cnt = 0`, → DRIVE.
- **DONE:** `done = 1`; `pass` is loaded with `(err_count == 0)`, using the count after the final SAMPLE update. DONE → IDLE unconditionally.
- **`start` outside IDLE:** ignored, including `start` held high through the run. `start` high in the DONE cycle is not accepted; it is accepted on the following IDLE cycle.
- **`err_count` width:** saturation is not needed; the maximum is 4.

## Timing
- **Reset values:** `A = 0`, `B = 0`, `busy = 0`, `done = 0`, `pass = 0`, `err_count = 0`, `fail_vec = 0`, state IDLE.
- **Per-vector time:** `SETTLE` DRIVE cycles + 1 SAMPLE cycle.
- **Run latency:** with `start` sampled at edge t0, `done` is high during the cycle following edge t0 + 4·(SETTLE+1). With `SETTLE = 1`, that is edge t0+8.
- **Stimulus-to-sample spacing:** `A`/`B` change at the edge entering DRIVE. The DUT outputs are sampled at the SAMPLE edge, exactly SETTLE+1 edges later.
- **Reset mid-run:** outputs return to reset values at once, and partial results are discarded. The next run requires a new `start`.

## Configuration
- **Macro:** `DEMORGAN_CHECK_HALT_EN`.
- **Defined:** SAMPLE with a mismatch goes directly to DONE, regardless of `vec`. `fail_vec` then has exactly one bit set, `err_count = 1`, and `pass = 0`.
- **Undefined:** all four vectors always run, and failures accumulate.

## Test plan
- **Correct DUT:** correct `demorgan` model, `SETTLE = 1`, `start` pulse → `A,B` sequence 00, 01, 10, 11; `done` at t0+8; `pass = 1`, `err_count = 0`, `fail_vec = 0000`.
- **`n_AandB` stuck at 1:** correct DUT except `n_AandB` stuck at 1 (macro undefined) → `fail_vec = 1000`, `err_count = 1`, `pass = 0`.
- **`nA` stuck at 0:** DUT `nA` stuck at 0 → `fail_vec = 0011`, `err_count = 2`; with `DEMORGAN_CHECK_HALT_EN` → `fail_vec = 0001`, `err_count = 1`, `done` at t0+2.
- **`SETTLE = 3`:** each `A`/`B` value is held 4 cycles; `done` at t0+16.
- **Reset mid-run:** `reset` asserted mid-run during vector 2 → all outputs 0 immediately; a later `start` completes normally with `pass = 1`.
- **`start` held high:** `start` held high for 20 cycles → the run completes once; a second run begins on the IDLE cycle after DONE; `pass` clears to 0 on that acceptance.
